ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the reverse direction of the existing PS/2 keyboard receiver path.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside PS2_Interface in skeleton.
- The top level converts its pull-low enables into the open-collector ps2_clock/ps2_data inouts: line = oe ? 1'b0 : 1'bz.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the host holds the clock low before the request (100 us at 50 MHz).
- START_TIMEOUT, 750000: max cycles from the request until the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000: max cycles from the first falling edge to the ack (2 ms).
- FILTER_LEN, 8: consecutive identical synchronized samples required to accept a clock level change.

Ports:
- clock, input, 1: system clock (50 MHz).
- reset, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: command byte.
- tx_valid, input, 1: request to send tx_data.
- tx_ready, output, 1: high only in IDLE; a byte is accepted when tx_valid && tx_ready.
- tx_done, output, 1: one-cycle pulse on an acknowledged frame.
- tx_error, output, 1: one-cycle pulse on a failed frame.
- err_code, output, 2: 01 = no device clock, 10 = frame timeout, 11 = no ack; held until the next accept.
- ps2_clk_in, input, 1: raw PS/2 clock line (asynchronous).
- ps2_data_in, input, 1: raw PS/2 data line (asynchronous).
- ps2_clk_oe, output, 1: 1 = pull the clock line low.
- ps2_data_oe, output, 1: 1 = pull the data line low.

Behaviour:
- Reset values: tx_ready=1, tx_done=0, tx_error=0, err_code=00, ps2_clk_oe=0, ps2_data_oe=0, state IDLE. Reset releases both lines immediately, asynchronously, including mid-frame.
- Input conditioning: 2-flop synchronizer on each line, then a FILTER_LEN filter on the clock. A falling edge is registered when the filtered clock goes 1->0. Pulses shorter than FILTER_LEN cycles are ignored.
- On accept: latch tx_data into shift[7:0] and latch parity = ~^tx_data (odd parity). tx_valid is ignored outside IDLE.
- States:
  - IDLE: clk_oe=0, data_oe=0. On accept -> INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles -> REQ.
  - REQ: clk_oe=1, data_oe=1 for exactly 1 cycle (start bit) -> WAIT_DEV.
  - WAIT_DEV: clk_oe=0, data_oe=1; start counter reset.
    - First falling edge: data_oe=~shift[0], bitcnt=1 -> DATA.
    - Counter reaches START_TIMEOUT: error 01.
  - DATA: on each falling edge drive the next bit, LSB first (data_oe = ~bit).
    - After bit7 has been driven, the next falling edge drives parity -> STOP.
  - STOP: on the next falling edge set data_oe=0 (stop bit, line released) -> ACK.
  - ACK: on the next falling edge sample the synchronized data line.
    - 0 -> WAIT_IDLE.
    - 1 -> error 11.
  - WAIT_IDLE: wait until both synchronized lines read 1, then pulse tx_done and go to IDLE.
- Falling-edge count: WAIT_DEV->DATA is edge 1, parity is edge 9, stop is edge 10, ack is edge 11.
- FRAME_TIMEOUT counts from edge 1 through WAIT_IDLE. Expiry in any of these states gives error 10.
- Error path: release both lines, pulse tx_error, set err_code, go to IDLE in the same cycle.
- tx_done and tx_error are never high together; tx_ready rises on the cycle after the pulse.
- Simultaneous timeout expiry and falling edge: the timeout wins.
- Counter widths: $clog2 of each limit + 1; bit counter 4 bits (0..11). No counter wraps; each is cleared on state entry.

Decomposition:
- Shared package ps2_pkg:
  - State enum.
  - Error code constants ERR_NONE, ERR_NOCLK, ERR_FRAME, ERR_NOACK.
  - Command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4.
- One sub-module ps2_line_filter: synchronizer plus FILTER_LEN filter; outputs a filtered level and a fall pulse. The same sub-module is reusable by the receiver.

Test Plan:
- INHIBIT_CYCLES=50. Send 0xED with a device model clocking at 12.5 kHz and acking -> clk_oe high exactly 50 cycles; the device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device acks -> one tx_done pulse, err_code=00, tx_ready=1 next cycle.
- Send 0x01 -> parity bit 0. Send 0xFF -> parity bit 1. Both complete with tx_done.
- No device (clock stays high), START_TIMEOUT=200 -> tx_error pulse exactly 200 cycles after WAIT_DEV entry, err_code=01, both oe=0.
- Device clocks 11 edges but leaves data high on edge 11 -> tx_error, err_code=11. Device stops after edge 5, FRAME_TIMEOUT=1000 -> err_code=10.
- Assert reset during DATA bit 3 -> ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1 with no clock edge. After release, a new 0xF4 frame completes normally.
- 3-cycle clock glitch low (FILTER_LEN=8) in WAIT_DEV -> no edge counted, data_oe stays 1. A second tx_valid pulse during DATA is ignored, so exactly one tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line conditioning.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StWaitDev,
    StData,
    StStop,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NOCLK = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a level filter for a PS/2 line; reports the filtered
// level and a one-cycle pulse when the filtered level falls.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q;

  // Bring the asynchronous line into the clock domain; idle PS/2 lines are high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line};
    end
  end

  // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state and the registered falling-edge pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= level_q & ~level_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts a command byte out on device-generated clock falls, then checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned FRAME_TIMEOUT  = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned SW = $clog2(START_TIMEOUT) + 1;
  localparam int unsigned FW = $clog2(FRAME_TIMEOUT) + 1;

  ps2_state_e    state_q, state_d;
  logic [IW-1:0] inh_cnt_q;
  logic [SW-1:0] start_cnt_q;
  logic [FW-1:0] frame_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          drv_q;      // pull-low value for the data line while a bit is on the wire
  logic [1:0]    err_q;
  logic [1:0]    data_sync_q;
  logic          clk_level, clk_fall;
  logic          accept, inh_done, start_expired, frame_expired, frame_state;
  logic [1:0]    fail_code;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock(clock),
    .reset(reset),
    .line (ps2_clk_in),
    .level(clk_level),
    .fall (clk_fall)
  );

  // Data line is only sampled at clock falls, so a plain synchronizer suffices.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign accept        = tx_valid && (state_q == StIdle);
  assign inh_done      = (inh_cnt_q == IW'(INHIBIT_CYCLES - 1));
  assign start_expired = (start_cnt_q == SW'(START_TIMEOUT));
  assign frame_expired = (frame_cnt_q == FW'(FRAME_TIMEOUT));
  assign frame_state   = (state_q == StData) || (state_q == StStop) ||
                         (state_q == StAck) || (state_q == StWaitIdle);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout takes priority over a coincident clock fall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StInhibit;
      StInhibit:  if (inh_done) state_d = StReq;
      StReq:      state_d = StWaitDev;
      StWaitDev: begin
        if (start_expired) state_d = StIdle;
        else if (clk_fall) state_d = StData;
      end
      StData: begin
        if (frame_expired) state_d = StIdle;
        else if (clk_fall && (bit_cnt_q == 4'd8)) state_d = StStop;
      end
      StStop: begin
        if (frame_expired) state_d = StIdle;
        else if (clk_fall) state_d = StAck;
      end
      StAck: begin
        if (frame_expired) state_d = StIdle;
        else if (clk_fall) state_d = data_sync_q[1] ? StIdle : StWaitIdle;
      end
      StWaitIdle: begin
        if (frame_expired || (clk_level && data_sync_q[1])) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  // Line enables, handshake and completion pulses; a failing cycle already releases both lines.
  always_comb begin
    tx_ready    = (state_q == StIdle);
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    fail_code   = ERR_NONE;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      StInhibit: ps2_clk_oe = 1'b1;
      StReq: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      StWaitDev: begin
        ps2_data_oe = 1'b1;
        tx_error    = start_expired;
        fail_code   = ERR_NOCLK;
      end
      StData, StStop: begin
        ps2_data_oe = drv_q;
        tx_error    = frame_expired;
        fail_code   = ERR_FRAME;
      end
      StAck: begin
        tx_error  = frame_expired || (clk_fall && data_sync_q[1]);
        fail_code = frame_expired ? ERR_FRAME : ERR_NOACK;
      end
      StWaitIdle: begin
        tx_error  = frame_expired;
        tx_done   = !frame_expired && clk_level && data_sync_q[1];
        fail_code = ERR_FRAME;
      end
      default: ;
    endcase
    if (tx_error) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
    end
  end

  // Phase counters; each restarts whenever its phase is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inh_cnt_q   <= '0;
      start_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      inh_cnt_q   <= (state_q == StInhibit) ? inh_cnt_q + 1'b1 : '0;
      start_cnt_q <= (state_q == StWaitDev) ? start_cnt_q + 1'b1 : '0;
      if (state_q == StWaitDev) begin
        frame_cnt_q <= '0;
      end else if (frame_state) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Byte capture, bit sequencing on clock falls and the sticky error code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      drv_q     <= 1'b0;
      bit_cnt_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      if (accept) begin
        shift_q   <= tx_data;
        parity_q  <= odd_parity(tx_data);
        bit_cnt_q <= '0;
        err_q     <= ERR_NONE;
      end
      if (clk_fall && !tx_error) begin
        if ((state_q == StWaitDev) || ((state_q == StData) && (bit_cnt_q != 4'd8))) begin
          drv_q     <= ~shift_q[0];
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end else if (state_q == StData) begin
          drv_q     <= ~parity_q;
          bit_cnt_q <= 4'd9;
        end else if (state_q == StStop) begin
          drv_q     <= 1'b0;
          bit_cnt_q <= 4'd10;
        end else if (state_q == StAck) begin
          bit_cnt_q <= 4'd11;
        end
      end
      if (tx_error) begin
        err_q <= fail_code;
      end
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks frames in and checks the bits,
// while a monitor pops expected done/error responses whenever the DUT pulses.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  // Device clock half period in system cycles (scaled down from 12.5 kHz to keep runs short).
  localparam int HALF = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  wire        ps2_data_in = dev_data & ~ps2_data_oe;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [2:0] resp_q[$];   // {is_error, err_code}
  logic [2:0] r;
  logic       post_pending = 1'b0;
  logic [1:0] post_code = 2'b00;

  logic [7:0] v_data [3] = '{8'hED, 8'h01, 8'hFF};
  logic       v_par  [3] = '{1'b1, 1'b0, 1'b1};

  ps2_host_tx #(
    .INHIBIT_CYCLES(50),
    .START_TIMEOUT (200),
    .FRAME_TIMEOUT (1000),
    .FILTER_LEN    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .err_code   (err_code),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic is_err, input logic [1:0] code);
    resp_q.push_back({is_err, code});
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(tx_ready && resp_q.size() == 0) && t < 5000) begin
      @(negedge clock);
      t++;
    end
    check("idle_wait_pending", resp_q.size(), 0);
  endtask

  // Device model: observe inhibit/request, then generate n_edges clock pulses, sampling data
  // at the end of each low phase and optionally acknowledging on edge 11.
  task automatic dev_run(input int n_edges, input logic ack, input logic chk, input logic glitch,
                         input logic [7:0] exp_d, input logic exp_p);
    int          t = 0;
    int          inh = 0;
    int          req = 0;
    logic [10:0] got = '1;
    while (t < 3000) begin
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) req++;
      else if (!ps2_clk_oe && ps2_data_oe) break;
      @(negedge clock);
      t++;
    end
    check("request_seen", int'(t < 3000), 1);
    if (t >= 3000) return;
    check("inhibit_len", inh, 50);
    check("req_len", req, 1);
    got[0] = ps2_data_in;
    if (glitch) begin
      repeat (10) @(negedge clock);
      dev_clk = 1'b0;
      repeat (3) @(negedge clock);
      dev_clk = 1'b1;
      repeat (20) @(negedge clock);
      check("glitch_data_oe", int'(ps2_data_oe), 1);
    end
    repeat (HALF) @(negedge clock);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      if (e <= 10) got[e] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clock);
    end
    dev_data = 1'b1;
    if (chk) begin
      check("start_bit", int'(got[0]), 0);
      check("data_bits", int'(got[8:1]), int'(exp_d));
      check("parity_bit", int'(got[9]), int'(exp_p));
      check("stop_bit", int'(got[10]), 1);
    end
  endtask

  // Scoreboard monitor: pop on every done/error pulse, then check the following cycle.
  always @(negedge clock) begin
    if (reset) begin
      post_pending = 1'b0;
    end else begin
      if (post_pending) begin
        check("ready_after_pulse", int'(tx_ready), 1);
        check("err_code", int'(err_code), int'(post_code));
        check("lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
        post_pending = 1'b0;
      end
      if (tx_done || tx_error) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (resp_q.size() == 0) begin
          check("unexpected_resp", int'({tx_done, tx_error}), 0);
        end else begin
          r = resp_q.pop_front();
          check("resp_kind", int'({tx_done, tx_error}), r[2] ? 1 : 2);
          check("ready_in_pulse", int'(tx_ready), 0);
          if (tx_error) check("oe_in_err_pulse", int'({ps2_clk_oe, ps2_data_oe}), 0);
          post_code    = r[1:0];
          post_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int e_cyc;
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #2;
    check("rst_ready", int'(tx_ready), 1);
    check("rst_done", int'(tx_done), 0);
    check("rst_error", int'(tx_error), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Acknowledged frames with hand-computed parity.
    for (int i = 0; i < 3; i++) begin
      expect_resp(1'b0, 2'b00);
      send(v_data[i]);
      dev_run(11, 1'b1, 1'b1, 1'b0, v_data[i], v_par[i]);
      wait_idle();
    end

    // Device clocks all edges but never acks.
    expect_resp(1'b1, 2'b11);
    send(CMD_ENABLE);
    dev_run(11, 1'b0, 1'b1, 1'b0, 8'hF4, 1'b0);
    wait_idle();

    // No device: start timeout measured from the first WAIT_DEV cycle.
    expect_resp(1'b1, 2'b01);
    send(CMD_RESET);
    t = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && t < 500) begin
      @(negedge clock);
      t++;
    end
    e_cyc = cyc;
    while (!tx_error && t < 1500) begin
      @(negedge clock);
      t++;
    end
    check("start_timeout_len", cyc - e_cyc, 200);
    wait_idle();

    // Device stops after edge 5.
    expect_resp(1'b1, 2'b10);
    send(8'h3C);
    dev_run(5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_idle();

    // Asynchronous reset while bit 3 (a zero) is on the wire.
    send(8'h00);
    dev_run(4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    check("pre_reset_data_oe", int'(ps2_data_oe), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    check("async_rst_ready", int'(tx_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    expect_resp(1'b0, 2'b00);
    send(CMD_ENABLE);
    dev_run(11, 1'b1, 1'b1, 1'b0, 8'hF4, 1'b0);
    wait_idle();

    // Short clock glitch in WAIT_DEV and a stray request mid-frame.
    expect_resp(1'b0, 2'b00);
    send(8'hA5);
    fork
      dev_run(11, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1);
      begin
        repeat (300) @(negedge clock);
        check("busy_mid_frame", int'(tx_ready), 0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
      end
    join
    wait_idle();

    repeat (100) @(negedge clock);
    check("total_done", done_cnt, 5);
    check("total_error", err_cnt, 3);
    check("final_queue", resp_q.size(), 0);
    check("final_ready", int'(tx_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
